// File: rtl/ca_prng_arbiter.sv
// Sequences a shared CA PRNG (seed, warm-up, word fill) and hands each fresh word to one requester.
// Optional grant/reseed statistics are enabled by defining CA_PRNG_ARB_STATS_EN.
module ca_prng_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int N           = 10,
    parameter int ARRAY_WIDTH = 11,
    parameter int WARMUP      = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [ARRAY_WIDTH-1:0] i_seed,
    input  logic                   i_reseed,
    input  logic [NUM_REQ-1:0]     i_req,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic                   o_valid,
    output logic [N-1:0]           o_data,
    output logic                   o_busy,
    output logic                   o_prng_rst_n,
    output logic                   o_prng_en,
`ifdef CA_PRNG_ARB_STATS_EN
    output logic [15:0]            o_gnt_total,
    output logic [7:0]             o_reseed_cnt,
`endif
    input  logic [N-1:0]           i_prng_rn
);

    localparam int CMAX  = (WARMUP > N) ? WARMUP : N;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam int PW    = $clog2(NUM_REQ);

    typedef enum logic [2:0] {SEED, WARM, FILL, READY, GRANT} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [PW-1:0]        ptr, ptr_next;
    logic [NUM_REQ-1:0]   gnt_next;
    logic [NUM_REQ-1:0]   pick;
    logic [PW-1:0]        pick_idx;
    logic                 load;

    // The seed goes straight to the PRNG; it is folded here only so it is not left dangling.
    logic seed_unused;
    assign seed_unused = ^i_seed;

    // Round-robin search starting just past the last winner, wrapping around.
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        pick     = '0;
        pick_idx = ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && i_req[idx[PW-1:0]]) begin
                found               = 1'b1;
                pick[idx[PW-1:0]]   = 1'b1;
                pick_idx            = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        gnt_next   = '0;
        load       = 1'b0;
        case (state)
            SEED: begin
                state_next = WARM;
                cnt_next   = '0;
            end
            WARM: begin
                if (cnt == CNT_W'(WARMUP - 1)) begin
                    state_next = FILL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            FILL: begin
                if (cnt == CNT_W'(N - 1)) begin
                    state_next = READY;
                    cnt_next   = '0;
                    load       = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READY: begin
                if (|i_req) begin
                    state_next = GRANT;
                    gnt_next   = pick;
                    ptr_next   = pick_idx;
                end
            end
            GRANT: begin
                state_next = FILL;
                cnt_next   = '0;
            end
            default: state_next = SEED;
        endcase
        // Reseed overrides everything except the pointer; a grant already on the wire completes.
        if (i_reseed) begin
            state_next = SEED;
            cnt_next   = '0;
            gnt_next   = '0;
            ptr_next   = ptr;
            load       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= SEED;
            cnt    <= '0;
            ptr    <= PW'(NUM_REQ - 1);
            o_gnt  <= '0;
            o_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
            o_gnt <= gnt_next;
            if (load) o_data <= i_prng_rn;
        end
    end

    assign o_valid      = |o_gnt;
    assign o_busy       = (state == SEED) || (state == WARM) || (state == FILL);
    assign o_prng_rst_n = (state != SEED);
    assign o_prng_en    = (state == WARM) || (state == FILL);

`ifdef CA_PRNG_ARB_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_gnt_total  <= '0;
            o_reseed_cnt <= '0;
        end else begin
            if (|gnt_next && o_gnt_total != 16'hFFFF) o_gnt_total <= o_gnt_total + 1'b1;
            if (i_reseed && o_reseed_cnt != 8'hFF)    o_reseed_cnt <= o_reseed_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ca_prng_arbiter.sv
// Scoreboard bench for ca_prng_arbiter: directed stimulus pushes expected grants, a monitor pops and compares.
module tb_ca_prng_arbiter;

    localparam int NUM_REQ = 4;
    localparam int N       = 10;
    localparam int AW      = 11;
    localparam int WARMUP  = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [AW-1:0]      seed = 11'b00000100000;
    logic               reseed = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] gnt;
    logic               valid;
    logic [N-1:0]       data;
    logic               busy;
    logic               prng_rst_n;
    logic               prng_en;
    logic [N-1:0]       rn;

    ca_prng_arbiter #(.NUM_REQ(NUM_REQ), .N(N), .ARRAY_WIDTH(AW), .WARMUP(WARMUP)) dut (
        .i_clk(clk), .i_rst(rst), .i_seed(seed), .i_reseed(reseed), .i_req(req),
        .o_gnt(gnt), .o_valid(valid), .o_data(data), .o_busy(busy),
        .o_prng_rst_n(prng_rst_n), .o_prng_en(prng_en), .i_prng_rn(rn)
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in PRNG output: loads the low seed bits while held in reset, then counts every clock.
    always @(posedge clk) begin
        if (!prng_rst_n) rn <= seed[N-1:0];
        else             rn <= rn + 1'b1;
    end

    typedef struct {
        logic [NUM_REQ-1:0] gnt;
        logic [N-1:0]       data;
        int                 cyc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic push(input logic [NUM_REQ-1:0] g, input logic [N-1:0] d, input int c);
        exp_t e;
        e.gnt = g; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor: every grant must match the next queued expectation.
    always @(negedge clk) begin
        if (valid === 1'b1 || gnt !== '0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got gnt=%b data=%0d at cycle %0d, expected no grant",
                         gnt, data, cyc - base);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("grant_vector", 32'(gnt), 32'(e.gnt));
                check("grant_data", 32'(data), 32'(e.data));
                check("grant_cycle", cyc - base, e.cyc);
                check("grant_valid", 32'(valid), 1);
            end
        end
    end

    task automatic wait_to(input int k);
        while (cyc - base < k) @(negedge clk);
    endtask

    task automatic release_and_boot();
        int en_cnt, rst_low, first_ready, valid_seen;
        logic [N-1:0] data27;
        en_cnt = 0; rst_low = 0; first_ready = -1; valid_seen = 0; data27 = '0;
        @(negedge clk);
        rst  = 1'b1;
        base = cyc;
        #1;
        check("c0_prng_rst_n", 32'(prng_rst_n), 0);
        check("c0_busy", 32'(busy), 1);
        check("c0_valid", 32'(valid), 0);
        for (int k = 1; k <= 30; k++) begin
            wait_to(k);
            en_cnt  += int'(prng_en);
            rst_low += int'(!prng_rst_n);
            if (!busy && first_ready < 0) first_ready = k;
            if (k == 27) data27 = data;
            if (valid) valid_seen++;
        end
        check("boot_en_cycles", en_cnt, 26);
        check("boot_seed_after_c0", rst_low, 0);
        check("boot_first_ready", first_ready, 27);
        check("boot_word", 32'(data27), 57);
        check("boot_no_valid", valid_seen, 0);
        check("boot_word_held", 32'(data), 57);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_prng_rst_n", 32'(prng_rst_n), 0);
        check("rst_prng_en", 32'(prng_en), 0);

        release_and_boot();

        // All requesting: strict rotation, one grant every N+2 cycles.
        push(4'b0001, 10'd57, 31);
        push(4'b0010, 10'd72, 43);
        push(4'b0100, 10'd84, 55);
        push(4'b1000, 10'd96, 67);
        push(4'b0001, 10'd108, 79);
        req = 4'b1111;
        wait_to(80); req = 4'b0000;

        // Single requester, then wrap past the pointer.
        wait_to(82); req = 4'b0100; push(4'b0100, 10'd120, 91);
        wait_to(92); req = 4'b0101; push(4'b0001, 10'd132, 103);

        // Reseed in the 5th FILL cycle with a request pending; word sequence restarts.
        wait_to(104); req = 4'b0010; push(4'b0010, 10'd57, 137);
        wait_to(108); reseed = 1'b1;
        wait_to(109); reseed = 1'b0;
        check("reseed_busy", 32'(busy), 1);
        check("reseed_prng_rst_n", 32'(prng_rst_n), 0);
        wait_to(138); req = 4'b0000;

        // Reseed and request together in READY: reseed wins.
        wait_to(149); req = 4'b0001; reseed = 1'b1;
        wait_to(150);
        check("collide_busy", 32'(busy), 1);
        check("collide_prng_rst_n", 32'(prng_rst_n), 0);
        check("collide_valid", 32'(valid), 0);
        reseed = 1'b0; req = 4'b0000;

        // Reset during GRANT clears outputs at once.
        wait_to(152); req = 4'b0100; push(4'b0100, 10'd57, 178);
        wait_to(178);
        #2 rst = 1'b0; req = 4'b0000;
        #1;
        check("midrst_gnt", 32'(gnt), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_data", 32'(data), 0);
        check("midrst_busy", 32'(busy), 1);
        check("midrst_prng_en", 32'(prng_en), 0);

        release_and_boot();
        req = 4'b1111; push(4'b0001, 10'd57, 31);
        wait_to(32); req = 4'b0000;
        wait_to(45);
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ca_prng_arbiter.md
Name: ca_prng_arbiter

Overview:
- Controller and round-robin arbiter that shares one CA_PRNG instance between NUM_REQ requesters.
- Sequences the PRNG through seed load, warm-up and word fill, then latches a fresh N-bit word.
- Hands each word to exactly one requester via a one-cycle grant and never reuses a word.
- Sits between the CA_PRNG datapath and consumer blocks (e.g. pattern or address generators).

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- N, 10, random word width; must equal the PRNG N
- ARRAY_WIDTH, 11, CA grid width; must equal the PRNG ARRAY_WIDTH
- WARMUP, 16, enabled CA generations discarded after every seed load (>=1)

Ports:
- i_clk, input, 1, clock; all logic on posedge
- i_rst, input, 1, asynchronous active-low reset
- i_seed, input, ARRAY_WIDTH, seed value driven to the PRNG initial-value input
- i_reseed, input, 1, single-cycle pulse; forces a new seed/warm-up sequence
- i_req, input, NUM_REQ, per-requester level request; held until granted
- o_gnt, output, NUM_REQ, one-hot grant, asserted for one cycle
- o_valid, output, 1, high in the grant cycle only
- o_data, output, N, latched random word; valid when o_valid is high
- o_busy, output, 1, high in SEED/WARM/FILL
- o_prng_rst_n, output, 1, drives the PRNG i_rst; low loads the seed
- o_prng_en, output, 1, drives the PRNG i_en
- i_prng_rn, input, N, PRNG o_rn

Behaviour:
- Reset (i_rst low):
  - state=SEED, o_gnt=0, o_valid=0, o_data=0, o_busy=1, o_prng_rst_n=0, o_prng_en=0
  - cycle counter=0; round-robin pointer=NUM_REQ-1, so requester 0 has first priority
- FSM states and transitions:
  - SEED: o_prng_rst_n=0, o_prng_en=0 for exactly 1 cycle -> WARM.
  - WARM: o_prng_en=1 for WARMUP cycles; counter counts 0..WARMUP-1 -> FILL.
  - FILL: o_prng_en=1 for N cycles; counter counts 0..N-1. On the last FILL cycle, o_data <= i_prng_rn taken from the following edge, i.e. the word holds N bits produced in FILL. -> READY.
  - READY: o_prng_en=0 and o_busy=0; o_data held.
    - If any i_req bit is set: pick the first set bit scanning from pointer+1 upward with wrap; register that one-hot into o_gnt; move pointer to the winner -> GRANT.
    - Otherwise stay in READY indefinitely.
  - GRANT: o_gnt and o_valid high for 1 cycle -> FILL. A fresh word is always generated, so no word is issued twice.
- Latency:
  - After i_rst release, the first READY cycle is cycle 1+WARMUP+N (27 with defaults).
  - A request present in READY is granted on the next cycle.
  - Minimum spacing between grants is N+2 cycles.
- Requesters must drop i_req in the cycle after their grant. A request still high is treated as a new request.
- The PRNG o_rn shift register shifts every clock regardless of i_en. Only the latched o_data is valid; i_prng_rn is never passed through directly.
- i_reseed:
  - Sampled in every state. Next state is SEED, counter is cleared, and any pending grant is suppressed.
  - If i_reseed and a request arrive together in READY, i_reseed wins and no grant is issued.
  - If i_reseed arrives in GRANT, the current grant completes and the next state is SEED rather than FILL.
  - The round-robin pointer is not affected.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Any in-flight grant is lost.
- i_seed is only relevant while o_prng_rst_n=0. It must not be all-zero; behaviour with an all-zero seed is unspecified.
- Invariants: o_gnt is always one-hot or zero; o_valid equals the OR of o_gnt.

Optional Feature:
- Macro: CA_PRNG_ARB_STATS_EN.
- Defined:
  - Adds output o_gnt_total, 16 bits: a saturating count of grants since reset, holding at 16'hFFFF.
  - Adds output o_reseed_cnt, 8 bits: a saturating count of i_reseed pulses.
  - Both counters reset to 0.
- Not defined: both ports and counters are absent; there is no functional difference otherwise.

Test Plan:
- Release i_rst with defaults and seed 11'b00000100000 -> o_prng_rst_n low for 1 cycle, o_prng_en high for exactly 26 cycles, o_busy drops at cycle 27, o_data is stable and o_valid=0.
- Hold i_req=4'b1111 continuously -> grants occur in order 0001, 0010, 0100, 1000, 0001, with exactly 12 cycles between consecutive o_valid pulses.
- Hold i_req=4'b0100 only, then 4'b0101 after its grant -> grant 0100, then 0001 (wrap past pointer); no grant goes to unrequested bits.
- Pulse i_reseed during the 5th FILL cycle with a request pending -> SEED next cycle, no o_valid for the following 27 cycles. Running the same seed twice yields an identical o_data sequence.
- Pulse i_reseed and raise i_req together in READY -> no grant; o_busy=1 on the next cycle.
- Assert i_rst low during GRANT -> o_gnt, o_valid and o_data are 0 within the same cycle. After release, the sequence matches the first test exactly.
